// File: rtl/fsk_tx_scheduler_if.sv
// Byte-source side of the FSK transmit scheduler: valid/ready byte handshake plus burst abort.
// The source (master) drives data/valid/abort and the scheduler (slave) answers with ready.
interface fsk_tx_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_abort;

  modport master (output tx_data, output tx_valid, output tx_abort, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_abort, output tx_ready);
endinterface

// File: rtl/fsk_tx_scheduler.sv
// FSK burst framer: preamble, start, 8 data bits LSB first, stop, then a carrier-off guard.
// Carrier on one cycle after handshake; tx_ready only in IDLE or on the last stop-bit cycle.
module fsk_tx_scheduler #(
  parameter int BIT_CYCLES    = 5000,
  parameter int PREAMBLE_BITS = 16,
  parameter int GUARD_CYCLES  = 2500
) (
  input  logic                clk,
  input  logic                rst_n,
  fsk_tx_scheduler_if.slave   tx,
  output logic                mod_enable,
  output logic                mod_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int CW      = $clog2(BIT_CYCLES);
  localparam int IDX_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int IW      = $clog2(IDX_MAX);
  localparam int GW      = $clog2(GUARD_CYCLES + 1);

  localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] P_LAST = IW'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [IW-1:0] D_LAST = IW'(7);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_START, S_DATA, S_STOP, S_GUARD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [IW-1:0] idx, idx_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [7:0]    sh, sh_n;
  logic          done_n;
  logic          rdy_q, rdy_n;
  logic          en_n, data_n, busy_n;
  logic          bit_end, hs, on_air;

  assign tx.tx_ready = rdy_q;
  assign bit_end     = (cyc == C_LAST);
  assign hs          = tx.tx_valid && rdy_q;
  assign on_air      = (state inside {S_PREAMBLE, S_START, S_DATA, S_STOP});

  always_comb begin
    state_n = state;
    cyc_n   = bit_end ? '0 : cyc + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    gcnt_n  = '0;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cyc_n = '0;
        idx_n = '0;
        if (hs) begin
          sh_n    = tx.tx_data;
          state_n = (PREAMBLE_BITS == 0) ? S_START : S_PREAMBLE;
        end
      end
      S_PREAMBLE: if (bit_end) begin
        if (idx == P_LAST) begin
          idx_n   = '0;
          state_n = S_START;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_START: if (bit_end) begin
        idx_n   = '0;
        state_n = S_DATA;
      end
      S_DATA: if (bit_end) begin
        sh_n = {1'b0, sh[7:1]};
        if (idx == D_LAST) begin
          idx_n   = '0;
          state_n = S_STOP;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      // ready is only high on the final stop cycle, so a handshake here is a chained byte
      S_STOP: if (bit_end) begin
        if (hs) begin
          sh_n    = tx.tx_data;
          state_n = S_START;
        end else begin
          done_n  = 1'b1;
          state_n = S_GUARD;
        end
      end
      S_GUARD: begin
        cyc_n = '0;
        if (gcnt == G_LAST) state_n = S_IDLE;
        else                gcnt_n  = gcnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (tx.tx_abort && on_air) begin
      state_n = S_GUARD;
      cyc_n   = '0;
      idx_n   = '0;
      sh_n    = '0;
      gcnt_n  = '0;
      done_n  = 1'b0;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe
  always_comb begin
    en_n   = (state_n inside {S_PREAMBLE, S_START, S_DATA, S_STOP});
    busy_n = (state_n != S_IDLE);
    rdy_n  = (state_n == S_IDLE) || ((state_n == S_STOP) && (cyc_n == C_LAST));
    unique case (state_n)
      S_PREAMBLE: data_n = ~idx_n[0];
      S_START:    data_n = 1'b0;
      S_DATA:     data_n = sh_n[0];
      default:    data_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc        <= '0;
      idx        <= '0;
      gcnt       <= '0;
      sh         <= '0;
      rdy_q      <= 1'b1;
      mod_enable <= 1'b0;
      mod_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      idx        <= idx_n;
      gcnt       <= gcnt_n;
      sh         <= sh_n;
      rdy_q      <= rdy_n;
      mod_enable <= en_n;
      mod_data   <= data_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Bench for fsk_tx_scheduler: per-cycle mod_data scoreboard plus cycle-exact control checks.
module tb_fsk_tx_scheduler;
  localparam int BC = 4;
  localparam int PB = 4;
  localparam int GC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsk_tx_scheduler_if if0();
  fsk_tx_scheduler_if if1();

  logic en0, dat0, busy0, done0;
  logic en1, dat1, busy1, done1;

  fsk_tx_scheduler #(.BIT_CYCLES(BC), .PREAMBLE_BITS(PB), .GUARD_CYCLES(GC)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx(if0),
    .mod_enable(en0), .mod_data(dat0), .busy(busy0), .frame_done(done0)
  );

  fsk_tx_scheduler #(.BIT_CYCLES(BC), .PREAMBLE_BITS(0), .GUARD_CYCLES(GC)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx(if1),
    .mod_enable(en1), .mod_data(dat1), .busy(busy1), .frame_done(done1)
  );

  logic q0[$];
  logic q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic string at(input string s, input int c);
    return $sformatf("%s@%0d", s, c);
  endfunction

  // Expected modulator bit select, one entry per carrier-on cycle
  task automatic push_frame(input bit sel, input logic [7:0] b, input int pb);
    logic bits[$];
    bits = {};
    for (int i = 0; i < pb; i++) bits.push_back((i % 2) == 0);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < BC; k++) begin
        if (sel) q1.push_back(bits[i]);
        else     q0.push_back(bits[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (en0 === 1'b1) begin
      if (q0.size() == 0) chk("sb0_underrun", 1'b0, 1'b1);
      else                chk("sb0_data", dat0, q0.pop_front());
    end
    if (en1 === 1'b1) begin
      if (q1.size() == 0) chk("sb1_underrun", 1'b0, 1'b1);
      else                chk("sb1_data", dat1, q1.pop_front());
    end
  end

  initial begin
    if0.tx_data = '0; if0.tx_valid = 1'b0; if0.tx_abort = 1'b0;
    if1.tx_data = '0; if1.tx_valid = 1'b0; if1.tx_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_en", en0, 1'b0);
    chk("rst_data", dat0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_rdy", if0.tx_ready, 1'b1);
    chk("rst_rdy1", if1.tx_ready, 1'b1);
    tick();

    // single byte 0xA5, then a byte offered during the guard interval
    for (int c = 0; c <= 60; c++) begin
      if (c == 0)  begin if0.tx_valid = 1'b1; if0.tx_data = 8'hA5; push_frame(1'b0, 8'hA5, PB); end
      if (c == 1)  if0.tx_valid = 1'b0;
      if (c == 57) begin if0.tx_valid = 1'b1; if0.tx_data = 8'h3C; push_frame(1'b0, 8'h3C, PB); end
      @(negedge clk);
      chk(at("A_en", c), en0, (c >= 1 && c <= 56));
      chk(at("A_done", c), done0, (c == 57));
      chk(at("A_rdy", c), if0.tx_ready, (c == 0 || c == 56 || c == 60));
      chk(at("A_busy", c), busy0, (c >= 1 && c <= 59));
      if (!(c >= 1 && c <= 56)) chk(at("A_idle_data", c), dat0, 1'b1);
      tick();
    end

    // 0x3C was accepted at the end of the previous loop; reset it mid-burst
    for (int c = 1; c <= 22; c++) begin
      if (c == 1)  if0.tx_valid = 1'b0;
      if (c == 20) rst_n = 1'b0;
      if (c == 21) begin rst_n = 1'b1; q0.delete(); end
      @(negedge clk);
      if (c <= 20) begin
        chk(at("R_en", c), en0, 1'b1);
        chk(at("R_busy", c), busy0, 1'b1);
      end
      if (c == 21) begin
        chk("R_en_after", en0, 1'b0);
        chk("R_busy_after", busy0, 1'b0);
        chk("R_data_after", dat0, 1'b1);
      end
      if (c == 22) begin
        chk("R_rdy_released", if0.tx_ready, 1'b1);
        chk("R_en_released", en0, 1'b0);
      end
      tick();
    end

    // back-to-back 0x00 then 0xFF with valid held
    for (int c = 0; c <= 100; c++) begin
      if (c == 0)  begin if0.tx_valid = 1'b1; if0.tx_data = 8'h00; push_frame(1'b0, 8'h00, PB); end
      if (c == 1)  begin if0.tx_data = 8'hFF; push_frame(1'b0, 8'hFF, 0); end
      if (c == 57) if0.tx_valid = 1'b0;
      @(negedge clk);
      chk(at("B_en", c), en0, (c >= 1 && c <= 96));
      chk(at("B_done", c), done0, (c == 97));
      chk(at("B_rdy", c), if0.tx_ready, (c == 0 || c == 56 || c == 96 || c == 100));
      chk(at("B_busy", c), busy0, (c >= 1 && c <= 99));
      tick();
    end

    // abort in DATA, a held byte goes out after the guard
    for (int c = 0; c <= 94; c++) begin
      if (c == 0)  begin if0.tx_valid = 1'b1; if0.tx_data = 8'h5A; push_frame(1'b0, 8'h5A, PB); end
      if (c == 1)  if0.tx_data = 8'hC3;
      if (c == 30) if0.tx_abort = 1'b1;
      if (c == 31) begin if0.tx_abort = 1'b0; q0.delete(); push_frame(1'b0, 8'hC3, PB); end
      if (c == 35) if0.tx_valid = 1'b0;
      @(negedge clk);
      chk(at("C_en", c), en0, (c >= 1 && c <= 30) || (c >= 35 && c <= 90));
      chk(at("C_done", c), done0, (c == 91));
      chk(at("C_rdy", c), if0.tx_ready, (c == 0 || c == 34 || c == 90 || c == 94));
      chk(at("C_busy", c), busy0, (c >= 1 && c <= 33) || (c >= 35 && c <= 93));
      tick();
    end

    // no-preamble instance, byte 0x01
    for (int c = 0; c <= 44; c++) begin
      if (c == 0) begin if1.tx_valid = 1'b1; if1.tx_data = 8'h01; push_frame(1'b1, 8'h01, 0); end
      if (c == 1) if1.tx_valid = 1'b0;
      @(negedge clk);
      chk(at("E_en", c), en1, (c >= 1 && c <= 40));
      chk(at("E_done", c), done1, (c == 41));
      chk(at("E_rdy", c), if1.tx_ready, (c == 0 || c == 40 || c == 44));
      if (c >= 1 && c <= 4) chk(at("E_start", c), dat1, 1'b0);
      tick();
    end

    chk("sb0_drained", (q0.size() == 0), 1'b1);
    chk("sb1_drained", (q1.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
